memory_sdp: RTL and testbench

- Parametrised simple-dual-port RAM: one write port and one read port, on one clock, maps onto block RAM (DP16KD class).
- Adds byte-enable writes and a selectable read latency of 1 or 2.
- Adds defined read-during-write behaviour, a read-valid strobe and an optional clear-on-reset sweep.
- Serves as the storage primitive for FIFOs, step-profile tables and register files in the stepper design.

---
 rtl/memory_sdp.sv | 102 ++++++++++
 tb/tb_memory_sdp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_sdp.sv
// memory_sdp: simple-dual-port block RAM with byte enables, 1/2-cycle read latency and clear-on-reset sweep
module memory_sdp #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    DATA_SIZE      = 1024,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    READ_LATENCY   = 1,
  parameter int    WRITE_FIRST    = 0,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string PATH           = "",
  localparam int   NUM_BYTES      = DATA_WIDTH / BYTE_WIDTH,
  localparam int   ADDR_W         = DATA_SIZE > 1 ? $clog2(DATA_SIZE) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  output logic                  ready_out,
  input  logic                  wr_enable_in,
  input  logic [ADDR_W-1:0]     wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic [NUM_BYTES-1:0]  wr_byte_en_in,
  input  logic                  rd_enable_in,
  input  logic [ADDR_W-1:0]     rd_addr_in,
  output logic [DATA_WIDTH-1:0] r_rd_data_out,
  output logic                  r_rd_valid_out
);
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [ADDR_W:0]   SIZE = (ADDR_W + 1)'(DATA_SIZE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DATA_SIZE - 1);
  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("memory_sdp: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("memory_sdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate
  state_t                state;
  logic [ADDR_W-1:0]     cnt;
  logic [DATA_WIDTH-1:0] mem [DATA_SIZE];
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] d1;
  logic                  v1;
  initial for (int i = 0; i < DATA_SIZE; i++) mem[i] = '0;
  assign ready_out = state == READY;
  assign wr_ok     = ready_out && wr_enable_in && {1'b0, wr_addr_in} < SIZE;
  assign rd_ok     = ready_out && rd_enable_in;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= READY;
    end
  end
  always_ff @(posedge clk_in) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (wr_ok)
      for (int b = 0; b < NUM_BYTES; b++)
        if (wr_byte_en_in[b])
          mem[wr_addr_in][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_in[b*BYTE_WIDTH +: BYTE_WIDTH];
  end
  always_comb begin
    rd_word = mem[rd_addr_in];
    if (WRITE_FIRST != 0 && wr_ok && wr_addr_in == rd_addr_in)
      for (int b = 0; b < NUM_BYTES; b++)
        if (wr_byte_en_in[b])
          rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_in[b*BYTE_WIDTH +: BYTE_WIDTH];
    if ({1'b0, rd_addr_in} >= SIZE) rd_word = '0;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) d1 <= rd_word;
    end
  end
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end
      assign r_rd_valid_out = v2;
      assign r_rd_data_out  = d2;
    end else begin : g_lat1
      assign r_rd_valid_out = v1;
      assign r_rd_data_out  = d1;
    end
  endgenerate
endmodule

// File: tb/tb_memory_sdp.sv
// tb_memory_sdp: three configurations of memory_sdp (defaults; size 20 latency 2 write-first;
// size 16 clear-on-reset) checked against a per-cycle scoreboard of the RAM's documented behaviour.
module tb_memory_sdp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [3];
    logic        wr_en   [3];
    logic [9:0]  wr_addr [3];
    logic [31:0] wr_data [3];
    logic [3:0]  be      [3];
    logic        rd_en   [3];
    logic [9:0]  rd_addr [3];
    logic [31:0] rd_data [3];
    logic        rd_valid[3];
    logic        ready   [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int size [3] = '{1024, 20, 16};
    int lat  [3] = '{1, 2, 1};
    bit wf   [3] = '{1'b0, 1'b1, 1'b0};
    bit clr  [3] = '{1'b0, 1'b0, 1'b1};
    int amask[3] = '{1023, 31, 15};

    bit [31:0] mdl  [3][1024];
    int        sw   [3];
    bit        pv   [3][4];
    bit [31:0] pd   [3][4];
    bit [31:0] lastd[3];

    memory_sdp u0 (
        .clk_in(clk), .rst_n_in(rst_n[0]), .ready_out(ready[0]),
        .wr_enable_in(wr_en[0]), .wr_addr_in(wr_addr[0]), .wr_data_in(wr_data[0]), .wr_byte_en_in(be[0]),
        .rd_enable_in(rd_en[0]), .rd_addr_in(rd_addr[0]), .r_rd_data_out(rd_data[0]), .r_rd_valid_out(rd_valid[0])
    );
    memory_sdp #(.DATA_SIZE(20), .READ_LATENCY(2), .WRITE_FIRST(1)) u1 (
        .clk_in(clk), .rst_n_in(rst_n[1]), .ready_out(ready[1]),
        .wr_enable_in(wr_en[1]), .wr_addr_in(wr_addr[1][4:0]), .wr_data_in(wr_data[1]), .wr_byte_en_in(be[1]),
        .rd_enable_in(rd_en[1]), .rd_addr_in(rd_addr[1][4:0]), .r_rd_data_out(rd_data[1]), .r_rd_valid_out(rd_valid[1])
    );
    memory_sdp #(.DATA_SIZE(16), .CLEAR_ON_RESET(1)) u2 (
        .clk_in(clk), .rst_n_in(rst_n[2]), .ready_out(ready[2]),
        .wr_enable_in(wr_en[2]), .wr_addr_in(wr_addr[2][3:0]), .wr_data_in(wr_data[2]), .wr_byte_en_in(be[2]),
        .rd_enable_in(rd_en[2]), .rd_addr_in(rd_addr[2][3:0]), .r_rd_data_out(rd_data[2]), .r_rd_valid_out(rd_valid[2])
    );

    typedef struct {
        bit        we;
        int        wa;
        bit [31:0] wd;
        bit [3:0]  e;
        bit        re;
        int        ra;
        bit        ev;
        bit [31:0] ed;
    } vec_t;

    vec_t tbl[14];

    function automatic bit [31:0] merge(bit [31:0] o, bit [31:0] n, bit [3:0] e);
        for (int b = 0; b < 4; b++) if (e[b]) o[b*8 +: 8] = n[b*8 +: 8];
        return o;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %h want %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic drive(int k, bit we, int wa, bit [31:0] wd, bit [3:0] e, bit re, int ra);
        wr_en[k]   = we;
        wr_addr[k] = 10'(wa);
        wr_data[k] = wd;
        be[k]      = e;
        rd_en[k]   = re;
        rd_addr[k] = 10'(ra);
    endtask

    // One clock: predict each RAM's response from the pre-edge inputs, then compare after the edge.
    task automatic tick();
        int wa, ra, s;
        bit [31:0] d;
        bit ev;
        for (int k = 0; k < 3; k++) begin
            if (rst_n[k]) begin
                wa = int'(wr_addr[k]) & amask[k];
                ra = int'(rd_addr[k]) & amask[k];
                if (sw[k] == 0 && rd_en[k]) begin
                    d = ra < size[k] ? mdl[k][ra] : '0;
                    if (wf[k] && wr_en[k] && wa == ra && ra < size[k]) d = merge(d, wr_data[k], be[k]);
                    s = (cyc + lat[k]) % 4;
                    pv[k][s] = 1'b1;
                    pd[k][s] = d;
                end
                if (sw[k] == 0 && wr_en[k] && wa < size[k]) mdl[k][wa] = merge(mdl[k][wa], wr_data[k], be[k]);
                if (sw[k] > 0) begin
                    sw[k]--;
                    if (sw[k] == 0) for (int a = 0; a < 1024; a++) mdl[k][a] = '0;
                end
            end else begin
                for (int j = 0; j < 4; j++) pv[k][j] = 1'b0;
                sw[k]    = clr[k] ? size[k] : 0;
                lastd[k] = '0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            s  = cyc % 4;
            ev = pv[k][s];
            if (ev) lastd[k] = pd[k][s];
            pv[k][s] = 1'b0;
            chk("valid", k, 32'(rd_valid[k]), 32'(ev));
            chk("data", k, rd_data[k], lastd[k]);
            chk("ready", k, 32'(ready[k]), rst_n[k] ? 32'(sw[k] == 0) : 32'(!clr[k]));
        end
    endtask

    task automatic op(int k, bit we, int wa, bit [31:0] wd, bit [3:0] e, bit re, int ra);
        drive(k, we, wa, wd, e, re, ra);
        tick();
        drive(k, 1'b0, 0, '0, '0, 1'b0, 0);
    endtask

    task automatic expect_out(string nm, int k, bit v, bit [31:0] d);
        chk({nm, "_valid"}, k, 32'(rd_valid[k]), 32'(v));
        chk({nm, "_data"}, k, rd_data[k], d);
    endtask

    task automatic sweep_len(string nm, int rd_at);
        int lows = 0;
        for (int i = 0; i < 40 && !ready[2]; i++) begin
            lows++;
            if (i == rd_at) drive(2, 1'b0, 0, '0, '0, 1'b1, 2);
            tick();
            if (i == rd_at) chk("sweep_rd_valid", 2, 32'(rd_valid[2]), 32'd0);
            drive(2, 1'b0, 0, '0, '0, 1'b0, 0);
        end
        chk(nm, 2, 32'(lows), 32'd16);
    endtask

    task automatic read_all_zero(string nm);
        for (int a = 0; a < 16; a++) begin
            op(2, 1'b0, 0, '0, '0, 1'b1, a);
            expect_out(nm, 2, 1'b1, 32'h0);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5,    32'hDEADBEEF, 4'hF, 1'b0, 0,    1'b0, 32'h0};
        tbl[1]  = '{1'b0, 0,    32'h0,        4'h0, 1'b1, 5,    1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 0,    32'h0,        4'h0, 1'b0, 0,    1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 7,    32'h11223344, 4'hF, 1'b0, 0,    1'b0, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 7,    32'hAABBCCDD, 4'h5, 1'b0, 0,    1'b0, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, 0,    32'h0,        4'h0, 1'b1, 7,    1'b1, 32'h11BB33DD};
        tbl[6]  = '{1'b1, 7,    32'hFFFFFFFF, 4'h0, 1'b0, 0,    1'b0, 32'h11BB33DD};
        tbl[7]  = '{1'b0, 0,    32'h0,        4'h0, 1'b1, 7,    1'b1, 32'h11BB33DD};
        tbl[8]  = '{1'b1, 3,    32'h55,       4'hF, 1'b1, 3,    1'b1, 32'h0};
        tbl[9]  = '{1'b0, 0,    32'h0,        4'h0, 1'b1, 3,    1'b1, 32'h55};
        tbl[10] = '{1'b1, 3,    32'h66,       4'hF, 1'b1, 4,    1'b1, 32'h0};
        tbl[11] = '{1'b0, 0,    32'h0,        4'h0, 1'b1, 3,    1'b1, 32'h66};
        tbl[12] = '{1'b1, 1023, 32'hCAFEF00D, 4'hF, 1'b1, 1023, 1'b1, 32'h0};
        tbl[13] = '{1'b0, 0,    32'h0,        4'h0, 1'b1, 1023, 1'b1, 32'hCAFEF00D};

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            drive(k, 1'b0, 0, '0, '0, 1'b0, 0);
        end
        tick();
        tick();
        chk("rst_ready_clr", 2, 32'(ready[2]), 32'd0);
        chk("rst_ready_def", 0, 32'(ready[0]), 32'd1);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        sweep_len("power_up_sweep_len", -1);

        for (int i = 0; i < 14; i++) begin
            drive(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].e, tbl[i].re, tbl[i].ra);
            tick();
            chk("tbl_valid", 0, 32'(rd_valid[0]), 32'(tbl[i].ev));
            chk("tbl_data", 0, rd_data[0], tbl[i].ed);
        end
        drive(0, 1'b0, 0, '0, '0, 1'b0, 0);

        // Write-first collisions, latency 2
        op(1, 1'b1, 3, 32'h55, 4'hF, 1'b1, 3);        expect_out("wf_a", 1, 1'b0, 32'h0);
        op(1, 1'b1, 4, 32'h99, 4'hF, 1'b1, 3);        expect_out("wf_b", 1, 1'b1, 32'h55);
        op(1, 1'b1, 3, 32'hAABBCCDD, 4'h5, 1'b1, 3);  expect_out("wf_c", 1, 1'b1, 32'h55);
        tick();                                        expect_out("wf_d", 1, 1'b1, 32'h00BB00DD);
        tick();                                        expect_out("wf_e", 1, 1'b0, 32'h00BB00DD);
        op(1, 1'b1, 0, 32'hA, 4'hF, 1'b0, 0);
        op(1, 1'b1, 1, 32'hB, 4'hF, 1'b0, 0);
        op(1, 1'b1, 2, 32'hC, 4'hF, 1'b0, 0);
        op(1, 1'b0, 0, '0, '0, 1'b1, 0);              expect_out("l2_0", 1, 1'b0, 32'h00BB00DD);
        op(1, 1'b0, 0, '0, '0, 1'b1, 1);              expect_out("l2_1", 1, 1'b1, 32'hA);
        op(1, 1'b0, 0, '0, '0, 1'b1, 2);              expect_out("l2_2", 1, 1'b1, 32'hB);
        tick();                                        expect_out("l2_3", 1, 1'b1, 32'hC);
        tick();                                        expect_out("l2_4", 1, 1'b0, 32'hC);
        op(1, 1'b1, 25, 32'h12345678, 4'hF, 1'b0, 0);
        op(1, 1'b0, 0, '0, '0, 1'b1, 25);
        tick();                                        expect_out("oor_rd", 1, 1'b1, 32'h0);
        op(1, 1'b0, 0, '0, '0, 1'b1, 5);
        tick();                                        expect_out("oor_no_alias", 1, 1'b1, 32'h0);
        op(1, 1'b0, 0, '0, '0, 1'b1, 4);
        rst_n[1] = 1'b0;
        tick();                                        expect_out("rst_drop_a", 1, 1'b0, 32'h0);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();                                    expect_out("rst_drop_b", 1, 1'b0, 32'h0);
        end

        // Clear-on-reset sweep, then a sweep interrupted at cycle 8
        for (int a = 0; a < 16; a++) op(2, 1'b1, a, 32'hFF, 4'hF, 1'b0, 0);
        rst_n[2] = 1'b0;
        tick();
        rst_n[2] = 1'b1;
        sweep_len("sweep_len", 5);
        read_all_zero("clr");
        for (int a = 0; a < 16; a++) op(2, 1'b1, a, 32'hFF, 4'hF, 1'b0, 0);
        rst_n[2] = 1'b0;
        tick();
        rst_n[2] = 1'b1;
        repeat (8) tick();
        rst_n[2] = 1'b0;
        tick();
        rst_n[2] = 1'b1;
        sweep_len("restart_sweep_len", 3);
        read_all_zero("clr2");

        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 3; k++)
                drive(k, 1'($urandom_range(0, 1)), k == 0 ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 31)),
                      $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      k == 0 ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 31)));
            tick();
        end
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 0, '0, '0, 1'b0, 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
